// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared constants and Gray/binary conversions for the async FIFO pointer blocks
package async_fifo_pkg;
    localparam int FIFO_N = 4;
    localparam int MAXW = 32;

    function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs make the conversion width-independent; callers cast back to their width
    function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
        logic [MAXW-1:0] b;
        for (int i = 0; i < MAXW; i++) b[i] = ^(g >> i);
        return b;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing a Gray pointer into the local clock domain
module sync_2ff
    import async_fifo_pkg::*;
#(
    parameter int W = FIFO_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q1;

    always_ff @(posedge clk or posedge rst)
        if (rst) {q, q1} <= '0;
        else     {q, q1} <= {q1, d};
endmodule

// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer, Gray publish to the read side, and conservative full/almost-full flags
module wptr_full
    import async_fifo_pkg::*;
#(
    parameter int n        = FIFO_N,
    parameter int AF_LEVEL = 6
) (
    input  logic         wclk,
    input  logic         wrst,
    input  logic         winc,
    input  logic [n-1:0] rptr,
    output logic         wenable,
    output logic [n-2:0] waddr,
    output logic [n-1:0] wptr,
    output logic         wfull,
    output logic         wafull,
    output logic [n-1:0] wcount
);
    logic [n-1:0] wbin, wbinnext, wgraynext, wq2_rptr, rbin, next_count;

    sync_2ff #(.W(n)) u_sync (
        .clk(wclk),
        .rst(wrst),
        .d  (rptr),
        .q  (wq2_rptr)
    );

    always_comb begin
        wenable    = winc & ~wfull & ~wrst;
        wbinnext   = wbin + n'(winc & ~wfull);
        wgraynext  = n'(bin2gray(MAXW'(wbinnext)));
        rbin       = n'(gray2bin(MAXW'(wq2_rptr)));
        next_count = wbinnext - rbin;
    end

    assign waddr  = wbin[n-2:0];
    assign wcount = wbin - rbin;

    // Full when the next Gray pointer differs from the synced read pointer only in its top two bits
    always_ff @(posedge wclk or posedge wrst)
        if (wrst) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= wgraynext == {~wq2_rptr[n-1:n-2], wq2_rptr[n-3:0]};
            wafull <= next_count >= n'(AF_LEVEL);
        end
endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
Write-domain pointer and full-flag logic for the async FIFO. It sits directly upstream of the dual-clock memory and drives its `waddr` and `wenable`. It publishes a Gray-coded write pointer to the read domain. It brings the read domain's Gray pointer across into `wclk` and computes conservative full and almost-full flags from it.

Parameters:
- n, 4, pointer width in bits. Address width is n-1; FIFO depth is 2^(n-1) = 8 entries.
- AF_LEVEL, 6, occupancy at or above which `wafull` asserts. Legal range 1..2^(n-1)-1.

Ports:
- wclk  input  1  write-domain clock; the only clock in this block.
- wrst  input  1  asynchronous, active-high reset.
- winc  input  1  write request from the producer.
- rptr  input  n  Gray-coded read pointer, driven from the `rclk` domain.
- wenable  output  1  memory write enable, equal to `winc & ~wfull`.
- waddr  output  n-1  memory write address, equal to `wbin[n-2:0]`.
- wptr  output  n  registered Gray write pointer, sent to the read domain.
- wfull  output  1  registered full flag.
- wafull  output  1  registered almost-full flag.
- wcount  output  n  occupancy as seen from the write domain: `wbin - gray2bin(wq2_rptr)`, modulo 2^n.

Behaviour:
- Clocking and reset:
  - One clock, `wclk`. Reset is asynchronous and active-high on `wrst`.
  - While `wrst`=1, all of the following are 0: `wbin`, `wptr`, both synchronizer stages, `wfull`, `wafull`.
  - Consequently `waddr`=0, `wcount`=0 and `wenable`=0 during reset.
  - Reset asserted mid-operation clears everything immediately, with no clock edge required.
  - After deassertion, `wenable` follows `winc`.
- Accepted write:
  - A write is accepted when `winc`=1 and `wfull`=0 at a `wclk` posedge. The memory captures the data on that same edge at `waddr`.
  - `wbinnext = wbin + (winc & ~wfull)`.
  - `wgraynext = (wbinnext >> 1) ^ wbinnext`.
  - Both `wbin` and `wptr` register their next values every edge.
- Pointer wrap-around:
  - `wbin` wraps naturally from 2^n-1 to 0. With n=4, Gray goes 4'b1000 -> 4'b0000.
  - `waddr` wraps every 2^(n-1) writes.
- Synchronizer:
  - `rptr` passes through 2 flops: `wq1_rptr`, then `wq2_rptr`.
  - Latency is 2 `wclk` edges. No logic is placed between the flops.
- Full flag:
  - `wfull` <= (`wgraynext` == {~`wq2_rptr[n-1:n-2]`, `wq2_rptr[n-3:0]`}).
  - A write that fills the FIFO raises `wfull` on that same edge.
  - `wfull` clears on the 3rd `wclk` edge after `rptr` changes (2 edges to synchronize, 1 to register).
- Almost-full and count:
  - `wafull` <= ((`wbinnext` - `gray2bin(wq2_rptr)`) mod 2^n >= AF_LEVEL).
  - `wcount` is combinational from registered state.
- Blocked write: `winc`=1 while `wfull`=1 leaves `wenable`=0 and all pointers unchanged. No overflow ever occurs.
- Pessimism:
  - Full and almost-full are conservative, because the synchronized read pointer lags the real one.
  - They never indicate space that does not exist.
- Simultaneous events: a read-pointer change and a write in the same cycle are resolved against the stale `wq2_rptr`. This is correct and only conservative.
- Input assumption: `rptr` changes at most 1 bit per `rclk` and is registered at its source.

Decomposition:
- Package `async_fifo_pkg`:
  - functions `bin2gray` and `gray2bin`, parameterised on width;
  - default constant `FIFO_N`=4.
- Sub-module `sync_2ff`:
  - n-bit two-flop synchronizer with the same `wclk`/`wrst` style;
  - reused later for the read-side `rptr_empty` block.

Test Plan:
1. Reset: assert `wrst` with `winc`=1 mid-stream -> immediately `wptr`=0, `waddr`=0, `wfull`=0, `wafull`=0, `wenable`=0, `wcount`=0.
2. Fill: `rptr`=0, `winc`=1 for 8 cycles -> `waddr` 0..7 then 0, `wafull`=1 after the 6th write, `wfull`=1 after the 8th write, `wptr`=4'b1100, `wcount`=8.
3. Overflow block: a 9th `winc` while full -> `wenable`=0, `wptr` stays 4'b1100, `wbin` unchanged.
4. Drain release: with the FIFO full, set `rptr`=4'b0001 -> `wfull`=0 on the 3rd `wclk` edge; the next write is accepted at `waddr`=0.
5. Wrap: 16 writes with the read side tracking -> `wptr` sequence ends at 4'b1000 then 4'b0000, and `wfull` never falsely asserts.
6. Almost-full threshold: AF_LEVEL=6, `rptr` held at 0 -> `wafull` goes 0->1 exactly on the edge accepting the 6th write.
